// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file's single write port.
// It registers the granted result onto we/wn/d and tracks pending writes for RAW checks.
module regfile_wb_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             a_valid,
  input  logic [4:0]       a_rd,
  input  logic [31:0]      a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [4:0]       b_rd,
  input  logic [31:0]      b_data,
  output logic             b_ready,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  output logic             we,
  output logic [4:0]       wn,
  output logic [31:0]      d,
  output logic [31:0]      busy,
  output logic [CNT_W-1:0] wb_count
);

  logic        last_grant_b_reg;
  logic        grant_a;
  logic        grant_b;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic [31:0] busy_next;

  // On conflict the source that did not win last time gets the port.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (clrn) begin
      if (a_valid && (!b_valid || last_grant_b_reg))
        grant_a = 1'b1;
      else if (b_valid)
        grant_b = 1'b1;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    sel_rd   = b_rd;
    sel_data = b_data;
    if (grant_a) begin
      sel_rd   = a_rd;
      sel_data = a_data;
    end
  end

  // A fresh allocation beats the commit clearing the same register.
  assign busy_next[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      logic set_hit;
      logic clr_hit;
      assign set_hit       = alloc_valid && (alloc_rd == 5'(gi));
      assign clr_hit       = we && (wn == 5'(gi));
      assign busy_next[gi] = set_hit || (busy[gi] && !clr_hit);
    end
  endgenerate

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      last_grant_b_reg <= 1'b1;
      we               <= 1'b0;
      wn               <= 5'd0;
      d                <= 32'd0;
      busy             <= 32'd0;
      wb_count         <= '0;
    end else begin
      busy <= busy_next;
      if (we)
        wb_count <= wb_count + CNT_W'(1);
      if (grant_a || grant_b) begin
        last_grant_b_reg <= grant_b;
        we               <= (sel_rd != 5'd0);
        wn               <= sel_rd;
        d                <= sel_data;
      end else begin
        we <= 1'b0;
      end
    end
  end

endmodule
